// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the up/down counter sequencer.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/ud_mod_counter.sv
// Mod-(MAX+1) up/down counter with synchronous load and registered wrap pulse.
module ud_mod_counter
    import counter_seq_pkg::*;
#(
    parameter int unsigned MAX = 10,
    parameter int unsigned CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load,
    input  logic          dir,
    output logic [CW-1:0] count,
    output logic          wrap
);

    localparam logic [CW-1:0] TOP = CW'(MAX);

    logic          at_term;
    logic [CW-1:0] origin;

    assign at_term = (dir == DIR_DOWN) ? (count == '0) : (count == TOP);
    assign origin  = (dir == DIR_DOWN) ? TOP : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                count <= origin;
            end else if (en) begin
                // Stepping off the terminal value lands back on the origin.
                wrap <= at_term;
                if (at_term)
                    count <= origin;
                else if (dir == DIR_UP)
                    count <= count + 1'b1;
                else
                    count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Job sequencer: accepts (direction, laps) commands and runs the counter for that many wraps.
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int unsigned MAX   = 10,
    parameter int unsigned LAP_W = 8,
    localparam int unsigned CW   = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [LAP_W-1:0] cmd_laps,
    input  logic             pause,
    input  logic             abort,
    output logic [CW-1:0]    counter,
    output logic             carry,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic             aborted,
    output logic [LAP_W-1:0] laps_left
);

    state_t state;
    logic   dir_q;
    logic   accept;
    logic   start;
    logic   step_en;
    logic   at_term;
    logic   cnt_dir;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN) || (state == HOLD);
    assign paused    = (state == HOLD);

    assign accept  = cmd_valid & cmd_ready;
    assign start   = accept & (cmd_laps != '0);
    assign step_en = (state == RUN) & ~pause & ~abort;
    assign cnt_dir = start ? cmd_dir : dir_q;
    assign at_term = (dir_q == DIR_UP) ? (counter == CW'(MAX)) : (counter == '0);

    ud_mod_counter #(
        .MAX (MAX),
        .CW  (CW)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (step_en),
        .load  (start),
        .dir   (cnt_dir),
        .count (counter),
        .wrap  (carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dir_q     <= DIR_UP;
            laps_left <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cmd_laps == '0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= RUN;
                            dir_q     <= cmd_dir;
                            laps_left <= cmd_laps;
                        end
                    end
                end
                RUN: begin
                    // Abort outranks pause and a coincident final wrap.
                    if (abort) begin
                        state   <= IDLE;
                        aborted <= 1'b1;
                    end else if (pause) begin
                        state <= HOLD;
                    end else if (at_term) begin
                        laps_left <= laps_left - 1'b1;
                        if (laps_left == LAP_W'(1)) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (abort) begin
                        state   <= IDLE;
                        aborted <= 1'b1;
                    end else if (!pause) begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed and randomized checks of counter_seq_ctrl against a per-edge behavioural job model.
module tb_counter_seq_ctrl;

    localparam int unsigned MAX   = 10;
    localparam int unsigned LAP_W = 8;
    localparam int unsigned CW    = $clog2(MAX + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_dir = 1'b1;
    logic [LAP_W-1:0] cmd_laps = '0;
    logic             pause = 1'b0;
    logic             abort = 1'b0;
    logic [CW-1:0]    counter;
    logic             carry;
    logic             busy;
    logic             paused;
    logic             done;
    logic             aborted;
    logic [LAP_W-1:0] laps_left;

    counter_seq_ctrl #(
        .MAX   (MAX),
        .LAP_W (LAP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_laps  (cmd_laps),
        .pause     (pause),
        .abort     (abort),
        .counter   (counter),
        .carry     (carry),
        .busy      (busy),
        .paused    (paused),
        .done      (done),
        .aborted   (aborted),
        .laps_left (laps_left)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    // Job-level model: a job is active or not, possibly frozen, with a position and laps to go.
    bit m_active, m_frozen, m_up, m_carry, m_done, m_aborted;
    int m_pos, m_laps;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s/%s: observed %0d expected %0d", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_frozen = 0; m_up = 1;
        m_carry = 0; m_done = 0; m_aborted = 0;
        m_pos = 0; m_laps = 0;
    endtask

    task automatic model_edge();
        m_carry = 0; m_done = 0; m_aborted = 0;
        if (!m_active) begin
            if (cmd_valid) begin
                if (cmd_laps == 0) begin
                    m_done = 1;
                end else begin
                    m_active = 1; m_frozen = 0; m_up = cmd_dir;
                    m_pos  = cmd_dir ? 0 : int'(MAX);
                    m_laps = int'(cmd_laps);
                end
            end
        end else if (abort) begin
            m_active = 0; m_frozen = 0; m_aborted = 1;
        end else if (pause) begin
            m_frozen = 1;
        end else if (m_frozen) begin
            m_frozen = 0;
        end else begin
            if (m_up) m_pos = (m_pos + 1) % (MAX + 1);
            else      m_pos = (m_pos + MAX) % (MAX + 1);
            if (m_pos == (m_up ? 0 : int'(MAX))) begin
                m_carry = 1;
                m_laps  = m_laps - 1;
                if (m_laps == 0) begin
                    m_done = 1; m_active = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("cmd_ready", 32'(cmd_ready), 32'(!m_active));
        chk("busy",      32'(busy),      32'(m_active));
        chk("paused",    32'(paused),    32'(m_frozen));
        chk("counter",   32'(counter),   32'(m_pos));
        chk("carry",     32'(carry),     32'(m_carry));
        chk("done",      32'(done),      32'(m_done));
        chk("aborted",   32'(aborted),   32'(m_aborted));
        chk("laps_left", 32'(laps_left), 32'(m_laps));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send(input logic dir, input int laps);
        cmd_valid = 1'b1; cmd_dir = dir; cmd_laps = LAP_W'(laps);
        tick();
        cmd_valid = 1'b0;
    endtask

    int c1, c2, done_at, laps_at_c1, cnt_at_done;

    initial begin
        // Reset before any clock edge
        phase = "reset";
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1 rst = 1'b0;

        // Up, two laps
        phase = "up2";
        send(1'b1, 2);
        c1 = -1; c2 = -1; done_at = -1; laps_at_c1 = -1;
        for (int i = 1; i <= 40 && done_at < 0; i++) begin
            tick();
            if (carry === 1'b1) begin
                if (c1 < 0) begin c1 = i; laps_at_c1 = int'(laps_left); end
                else c2 = i;
            end
            if (done === 1'b1) done_at = i;
        end
        chk("carry1_cycle", 32'(c1), 32'd11);
        chk("carry2_cycle", 32'(c2), 32'd22);
        chk("done_cycle",   32'(done_at), 32'd22);
        chk("laps_at_c1",   32'(laps_at_c1), 32'd1);

        // Down, one lap
        phase = "down1";
        send(1'b0, 1);
        chk("load_max", 32'(counter), 32'(MAX));
        done_at = -1; cnt_at_done = -1;
        for (int i = 1; i <= 30 && done_at < 0; i++) begin
            tick();
            if (done === 1'b1) begin done_at = i; cnt_at_done = int'(counter); end
        end
        chk("done_cycle",   32'(done_at), 32'd11);
        chk("cnt_at_done",  32'(cnt_at_done), 32'(MAX));

        // Up, one lap, three stalled edges at counter 4
        phase = "pause";
        send(1'b1, 1);
        for (int i = 1; i <= 4; i++) tick();
        chk("cnt_before", 32'(counter), 32'd4);
        pause = 1'b1;
        tick();
        tick();
        chk("paused_hi", 32'(paused), 32'd1);
        chk("cnt_frozen", 32'(counter), 32'd4);
        pause = 1'b0;
        done_at = -1;
        for (int i = 7; i <= 40 && done_at < 0; i++) begin
            tick();
            if (done === 1'b1) done_at = i;
        end
        chk("done_cycle", 32'(done_at), 32'd14);

        // Abort on the final wrap edge
        phase = "abort";
        send(1'b1, 1);
        for (int i = 1; i <= 10; i++) tick();
        chk("cnt_at_term", 32'(counter), 32'(MAX));
        chk("laps_one",    32'(laps_left), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("aborted", 32'(aborted), 32'd1);
        chk("no_done", 32'(done), 32'd0);
        chk("no_carry", 32'(carry), 32'd0);
        chk("cnt_held", 32'(counter), 32'(MAX));
        tick();
        chk("idle_after", 32'(busy), 32'd0);

        // Zero-lap command, then a command held across a running job
        phase = "zero_laps";
        send(1'b1, 0);
        chk("done_zero", 32'(done), 32'd1);
        chk("cnt_kept",  32'(counter), 32'(MAX));
        phase = "backlog";
        send(1'b1, 1);
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_laps = LAP_W'(1);
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i == 5) chk("ready_low", 32'(cmd_ready), 32'd0);
        end
        chk("done_ready", 32'(cmd_ready & done), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("taken_busy", 32'(busy), 32'd1);
        chk("taken_cnt",  32'(counter), 32'(MAX));
        for (int i = 1; i <= 11; i++) tick();

        // Asynchronous reset mid-job
        phase = "rst_mid";
        send(1'b1, 3);
        for (int i = 1; i <= 5; i++) tick();
        chk("cnt_five", 32'(counter), 32'd5);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_cnt",   32'(counter), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        check_all();
        #2 rst = 1'b0;

        // Randomized traffic
        phase = "random";
        for (int i = 0; i < 600; i++) begin
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_dir   = 1'($urandom_range(0, 1));
            cmd_laps  = LAP_W'($urandom_range(0, 3));
            pause     = ($urandom_range(0, 6) == 0);
            abort     = ($urandom_range(0, 40) == 0);
            tick();
        end
        cmd_valid = 1'b0; pause = 1'b0; abort = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
